// File: rtl/corefifo_gray_conv_pipe.sv
// Pipelined Gray<->binary converter for COREFIFO pointers, with a valid/ready handshake.
// In Gray-to-binary mode, a step checker flags successive Gray codes that differ in more than one bit.
module corefifo_gray_conv_pipe #(
    parameter int ADDRWIDTH = 3,
    parameter int STAGES    = 2,
    parameter int CHK_EN    = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 in_mode,
    input  logic [ADDRWIDTH:0]   in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ADDRWIDTH:0]   out_data,
    output logic                 out_mode,
    output logic                 out_step_err
);
    localparam int W = ADDRWIDTH + 1;

    if (STAGES < 1 || STAGES > W) begin : g_bad_stages
        $error("corefifo_gray_conv_pipe: STAGES must be in 1..ADDRWIDTH+1");
    end

    // Bit i of the Gray-to-binary chain is resolved in this stage; the chain is spread evenly.
    function automatic int chunk_of(input int i);
        int den;
        den = (W > 1) ? (W - 1) : 1;
        return ((W - 2 - i) * STAGES) / den;
    endfunction

    // Bits above the stage's chunk are already binary, so each bit resolves in place.
    function automatic logic [W-1:0] resolve(input logic [W-1:0] d, input int k);
        logic [W-1:0] r;
        r = d;
        for (int i = W - 2; i >= 0; i--) begin
            if (chunk_of(i) == k) r[i] = r[i+1] ^ r[i];
        end
        return r;
    endfunction

    logic [W-1:0]      st_data [STAGES];
    logic [W-1:0]      nx_data [STAGES];
    logic [STAGES-1:0] st_valid;
    logic [STAGES-1:0] st_mode;
    logic [STAGES-1:0] st_err;
    logic [STAGES-1:0] ld;
    logic              step_err;

    always_comb begin
        ld[STAGES-1] = !st_valid[STAGES-1] || out_ready;
        for (int k = STAGES - 2; k >= 0; k--) begin
            ld[k] = !st_valid[k] || ld[k+1];
        end
    end

    always_comb begin
        nx_data[0] = in_mode ? (in_data ^ (in_data >> 1)) : resolve(in_data, 0);
        for (int k = 1; k < STAGES; k++) begin
            nx_data[k] = st_mode[k-1] ? st_data[k-1] : resolve(st_data[k-1], k);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            st_valid <= '0;
            st_mode  <= '0;
            st_err   <= '0;
            for (int k = 0; k < STAGES; k++) st_data[k] <= '0;
        end else begin
            if (ld[0]) begin
                st_valid[0] <= in_valid;
                st_data[0]  <= nx_data[0];
                st_mode[0]  <= in_mode;
                st_err[0]   <= step_err;
            end
            for (int k = 1; k < STAGES; k++) begin
                if (ld[k]) begin
                    st_valid[k] <= st_valid[k-1];
                    st_data[k]  <= nx_data[k];
                    st_mode[k]  <= st_mode[k-1];
                    st_err[k]   <= st_err[k-1];
                end
            end
        end
    end

    if (CHK_EN != 0) begin : g_chk
        logic [W-1:0] ref_gray;
        logic         ref_ok;

        assign step_err = !in_mode && ref_ok && ($countones(in_data ^ ref_gray) > 1);

        // Binary-mode traffic leaves the reference untouched.
        always_ff @(posedge clk) begin
            if (reset) begin
                ref_gray <= '0;
                ref_ok   <= 1'b0;
            end else if (in_valid && in_ready && !in_mode) begin
                ref_gray <= in_data;
                ref_ok   <= 1'b1;
            end
        end
    end else begin : g_no_chk
        assign step_err = 1'b0;
    end

    assign in_ready     = ld[0];
    assign out_valid    = st_valid[STAGES-1];
    assign out_data     = st_data[STAGES-1];
    assign out_mode     = st_mode[STAGES-1];
    assign out_step_err = st_err[STAGES-1];
endmodule
